load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator for the byte-addressed 64-bit data memory port (Mem_Addr, Write_Data, MemWrite, MemRead, Read_Data).
- Sits between the pipeline EX/MEM stage and the data memory.
- Accepts one load or store request at a time, sequences memory cycles, and returns sign- or zero-extended load data or a store acknowledge.
- Sub-doubleword stores use read-modify-write, because the memory port always writes 8 bytes.

Parameters:
- MEM_BYTES, 64: memory size in bytes. Any access with addr > MEM_BYTES-8 is out of range.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV64 size/sign code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, low bytes used.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  64  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected; no memory write occurred.
- Mem_Addr  out  64  memory address.
- Write_Data  out  64  memory write data.
- MemWrite  out  1  memory write strobe.
- MemRead  out  1  memory read enable.
- Read_Data  in  64  memory read data, combinational from Mem_Addr.

Behaviour:
- Reset values: state IDLE; all outputs 0 except req_ready=1. Internal request latches are cleared.
- States:
  - IDLE: req_ready=1. A request is accepted when req_valid=1 at the clk edge; addr, funct3, write and wdata are latched.
  - Next state from IDLE: error → RESP; load → RD; store d → WR; store b/h/w → RD.
  - RD: MemRead=1, Mem_Addr=latched addr. Read_Data is captured at the cycle end. Load → RESP; store → WR.
  - WR: MemWrite=1 for exactly this cycle. Mem_Addr=addr. Write_Data = captured doubleword with the low N bytes replaced by wdata (N = 1, 2, 4), or wdata for d. Next → RESP.
  - RESP: resp_valid=1. Stay until resp_ready=1, then → IDLE. req_ready=0 in every non-IDLE state.
- Latency from the accept edge to resp_valid: load 2 cycles; sd 2; sb/sh/sw 3; error 1.
- Load extension:
  - b/h/w sign-extend bits 7/15/31 of captured data.
  - bu/hu/wu zero-extend.
  - d passes through.
- Errors (resp_err=1, no MemRead/MemWrite issued):
  - load funct3=111;
  - store funct3 ≥ 100;
  - addr > MEM_BYTES-8.
- Outside RD and WR: MemRead=0, MemWrite=0. Mem_Addr and Write_Data hold their last values; no combinational path from req_* to memory outputs.
- Back-to-back: a new request can be accepted only in IDLE. There is no same-cycle accept on the RESP→IDLE edge.
- Address arithmetic: 64-bit unsigned; the range check must not wrap (addr near 2^64 is an error).
- Reset mid-operation: asynchronously returns to IDLE. MemWrite/MemRead drop immediately and the pending response is discarded. A partially completed read-modify-write leaves memory unmodified.

Optional Feature:
- LSU_MISALIGN_TRAP_EN
  - Defined: an access whose addr is not a multiple of its size (2/4/8) returns resp_err=1 with no memory access, 1-cycle latency.
  - Undefined: misaligned addresses are legal and handled identically to aligned ones (the memory is byte-addressed).

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - state enum (IDLE, RD, WR, RESP);
  - size-in-bytes function.
- One combinational sub-module, lsu_align, does load extraction/extension and store byte merge. The FSM stays in load_store_unit.

Test Plan:
- Memory initialised byte i = i+9; ld addr 0 → resp_rdata=0x100F0E0D0C0B0A09, resp_err=0, resp_valid 2 cycles after accept.
- sh wdata=0x8001 addr 8, then lh 8 → 0xFFFFFFFFFFFF8001; lhu 8 → 0x0000000000008001. Store shows MemRead for 1 cycle, then MemWrite for exactly 1 cycle.
- sb wdata=0xAA addr 16, then ld 16 → 0x201F1E1D1C1B1AAA; bytes 17–23 are unchanged.
- ld addr 60 (MEM_BYTES=64) → resp_err=1, resp_rdata=0, MemRead/MemWrite never asserted. Store funct3=100 behaves the same.
- Hold resp_ready=0 for 5 cycles after a load: resp_valid and resp_rdata stay stable, req_ready=0, and a request presented meanwhile is not accepted until IDLE.
- Assert reset during the WR cycle of sw addr 24: MemWrite falls immediately, no response is issued, req_ready=1 after reset, and ld 24 returns the original 0x2827262524232221.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV64 funct3 size/sign codes (F3_B .. F3_WU)
//   - FSM state enumeration (IDLE, RD, WR, RESP)
//   - size_bytes(): access size in bytes for a funct3 code
// No ports (package).
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Access size in bytes; unknown codes report a full doubleword.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        logic [3:0] n;
        case (funct3)
            F3_B, F3_BU: n = 4'd1;
            F3_H, F3_HU: n = 4'd2;
            F3_W, F3_WU: n = 4'd4;
            F3_D:        n = 4'd8;
            default:     n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational data steering for the load/store unit.
//   funct3      in  3   size/sign code of the latched request
//   mem_data    in  64  doubleword read from memory at the request address
//   store_data  in  64  store data (low bytes significant)
//   load_data   out 64  mem_data truncated and sign/zero extended
//   merge_data  out 64  mem_data with its low N bytes replaced by store_data
// The memory is byte addressed and returns the doubleword starting at the
// request address, so the wanted bytes are always the low-order ones.
// -----------------------------------------------------------------------------
module lsu_align import lsu_pkg::*; (
    input  logic [2:0]  funct3,
    input  logic [63:0] mem_data,
    input  logic [63:0] store_data,
    output logic [63:0] load_data,
    output logic [63:0] merge_data
);

    // Load extraction and sign/zero extension.
    always_comb begin
        load_data = 64'd0;
        case (funct3)
            F3_B:    load_data = {{56{mem_data[7]}},  mem_data[7:0]};
            F3_H:    load_data = {{48{mem_data[15]}}, mem_data[15:0]};
            F3_W:    load_data = {{32{mem_data[31]}}, mem_data[31:0]};
            F3_D:    load_data = mem_data;
            F3_BU:   load_data = {56'd0, mem_data[7:0]};
            F3_HU:   load_data = {48'd0, mem_data[15:0]};
            F3_WU:   load_data = {32'd0, mem_data[31:0]};
            default: load_data = 64'd0;
        endcase
    end

    // Store byte merge: low size_bytes(funct3) bytes come from store_data.
    always_comb begin
        logic [3:0] n;
        n          = size_bytes(funct3);
        merge_data = mem_data;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n) begin
                merge_data[8*i +: 8] = store_data[8*i +: 8];
            end else begin
                merge_data[8*i +: 8] = mem_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator for a byte-addressed 64-bit data memory port. Accepts one load or
// store at a time; sub-doubleword stores are performed as read-modify-write
// because the memory always writes 8 bytes.
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   req_valid/req_ready             request handshake
//   req_write, req_funct3           1 = store; RV64 size/sign code
//   req_addr, req_wdata             byte address; store data (low bytes)
//   resp_valid/resp_ready           response handshake
//   resp_rdata, resp_err            extended load data (0 for stores/errors); reject
//   Mem_Addr, Write_Data            memory address / write data (hold when idle)
//   MemWrite, MemRead               memory strobes, asserted only in WR / RD
//   Read_Data                       memory read data, combinational from Mem_Addr
// Build option: LSU_MISALIGN_TRAP_EN - when defined, accesses not aligned to
// their size are rejected with resp_err instead of being performed.
// All outputs are registered; nothing from req_* reaches the memory port
// combinationally.
// -----------------------------------------------------------------------------
module load_store_unit import lsu_pkg::*; #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [63:0] Read_Data
);

    // Highest legal start address; compared unsigned so wrapped addresses fail.
    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_BYTES) - 64'd8;

    lsu_state_t  state_r;
    lsu_state_t  state_next_s;

    logic [2:0]  funct3_r;
    logic        write_r;
    logic [63:0] wdata_r;

    logic        accept_s;
    logic        bad_f3_s;
    logic        range_s;
    logic        misalign_s;
    logic        err_s;

    logic [63:0] load_s;
    logic [63:0] merge_s;

    logic        req_ready_r,  req_ready_next_s;
    logic        resp_valid_r, resp_valid_next_s;
    logic [63:0] resp_rdata_r, resp_rdata_next_s;
    logic        resp_err_r,   resp_err_next_s;
    logic [63:0] mem_addr_r,   mem_addr_next_s;
    logic [63:0] write_data_r, write_data_next_s;
    logic        mem_write_r,  mem_write_next_s;
    logic        mem_read_r,   mem_read_next_s;

    assign accept_s = (state_r == IDLE) && req_valid;

    // Request legality: funct3 validity, address range, optional alignment.
    always_comb begin
        if (req_write) begin
            bad_f3_s = (req_funct3 >= F3_BU);
        end else begin
            bad_f3_s = (req_funct3 == 3'b111);
        end
        range_s    = (req_addr > ADDR_LIMIT);
        misalign_s = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_s = ((req_addr[3:0] & (size_bytes(req_funct3) - 4'd1)) != 4'd0);
`else
        misalign_s = 1'b0;
`endif
        err_s = bad_f3_s | range_s | misalign_s;
    end

    lsu_align u_align (
        .funct3     (funct3_r),
        .mem_data   (Read_Data),
        .store_data (wdata_r),
        .load_data  (load_s),
        .merge_data (merge_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode; doubleword stores skip the read phase.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!req_valid) begin
                    state_next_s = IDLE;
                end else if (err_s) begin
                    state_next_s = RESP;
                end else if (req_write && (req_funct3 == F3_D)) begin
                    state_next_s = WR;
                end else begin
                    state_next_s = RD;
                end
            end
            RD: begin
                if (write_r) begin
                    state_next_s = WR;
                end else begin
                    state_next_s = RESP;
                end
            end
            WR:   state_next_s = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Request latches, loaded on the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            funct3_r <= 3'd0;
            write_r  <= 1'b0;
            wdata_r  <= 64'd0;
        end else if (accept_s) begin
            funct3_r <= req_funct3;
            write_r  <= req_write;
            wdata_r  <= req_wdata;
        end else begin
            funct3_r <= funct3_r;
            write_r  <= write_r;
            wdata_r  <= wdata_r;
        end
    end

    // Output decode: next values of every registered output.
    always_comb begin
        req_ready_next_s  = (state_next_s == IDLE);
        resp_valid_next_s = (state_next_s == RESP);
        mem_read_next_s   = (state_next_s == RD);
        mem_write_next_s  = (state_next_s == WR);

        mem_addr_next_s = mem_addr_r;
        if (accept_s && !err_s) begin
            mem_addr_next_s = req_addr;
        end else begin
            mem_addr_next_s = mem_addr_r;
        end

        // Doubleword stores write req_wdata directly; narrower stores merge
        // into the doubleword captured at the end of RD.
        write_data_next_s = write_data_r;
        if (accept_s && !err_s && req_write && (req_funct3 == F3_D)) begin
            write_data_next_s = req_wdata;
        end else if ((state_r == RD) && write_r) begin
            write_data_next_s = merge_s;
        end else begin
            write_data_next_s = write_data_r;
        end

        resp_rdata_next_s = resp_rdata_r;
        if (accept_s) begin
            resp_rdata_next_s = 64'd0;
        end else if ((state_r == RD) && !write_r) begin
            resp_rdata_next_s = load_s;
        end else if ((state_r == RESP) && resp_ready) begin
            resp_rdata_next_s = 64'd0;
        end else begin
            resp_rdata_next_s = resp_rdata_r;
        end

        resp_err_next_s = resp_err_r;
        if (accept_s) begin
            resp_err_next_s = err_s;
        end else if ((state_r == RESP) && resp_ready) begin
            resp_err_next_s = 1'b0;
        end else begin
            resp_err_next_s = resp_err_r;
        end
    end

    // Output registers; reset drops the strobes and any pending response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 64'd0;
            resp_err_r   <= 1'b0;
            mem_addr_r   <= 64'd0;
            write_data_r <= 64'd0;
            mem_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
        end else begin
            req_ready_r  <= req_ready_next_s;
            resp_valid_r <= resp_valid_next_s;
            resp_rdata_r <= resp_rdata_next_s;
            resp_err_r   <= resp_err_next_s;
            mem_addr_r   <= mem_addr_next_s;
            write_data_r <= write_data_next_s;
            mem_write_r  <= mem_write_next_s;
            mem_read_r   <= mem_read_next_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign Mem_Addr   = mem_addr_r;
    assign Write_Data = write_data_r;
    assign MemWrite   = mem_write_r;
    assign MemRead    = mem_read_r;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a byte-array reference memory model.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int MEMB = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] Read_Data;

    load_store_unit #(.MEM_BYTES(MEMB)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .Mem_Addr   (Mem_Addr),
        .Write_Data (Write_Data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Read_Data  (Read_Data)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT port.
    logic [7:0] dut_mem [0:MEMB-1];
    logic       mem_load;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < MEMB; i++) dut_mem[i] <= 8'(i + 9);
        end else if (MemWrite && (Mem_Addr <= 64'(MEMB - 8))) begin
            for (int i = 0; i < 8; i++) dut_mem[Mem_Addr[5:0] + 6'(i)] <= Write_Data[8*i +: 8];
        end
    end

    always_comb begin
        Read_Data = 64'd0;
        if (Mem_Addr <= 64'(MEMB - 8)) begin
            for (int i = 0; i < 8; i++) Read_Data[8*i +: 8] = dut_mem[Mem_Addr[5:0] + 6'(i)];
        end
    end

    // Reference model state and expectations for the current transaction.
    logic [7:0]  ref_mem [0:MEMB-1];
    logic        exp_err;
    logic [63:0] exp_rdata;
    logic [63:0] exp_maddr;
    logic [63:0] exp_wmem;
    int          exp_lat, exp_rd, exp_wr;
    logic        cur_w;
    logic        active;
    int          rd_cnt, wr_cnt;
    int          tests, fails;
    logic [63:0] got;
    logic        gerr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // One cycle: advance to the falling edge and compare outputs to the model.
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            if (!active) begin
                check("no_mem_when_idle", {62'd0, MemRead, MemWrite}, 64'd0);
            end else begin
                if (MemRead) begin
                    rd_cnt++;
                    check("rd_addr", Mem_Addr, exp_maddr);
                end
                if (MemWrite) begin
                    wr_cnt++;
                    check("wr_addr", Mem_Addr, exp_maddr);
                    check("wr_data", Write_Data, exp_wmem);
                end
                if (resp_valid) begin
                    check("resp_rdata", resp_rdata, exp_rdata);
                    check("resp_err", {63'd0, resp_err}, {63'd0, exp_err});
                    check("req_ready_busy", {63'd0, req_ready}, 64'd0);
                end
            end
        end
    endtask

    // Derive the expected outcome of a request from the reference memory.
    task automatic model_expect(input logic w, input logic [2:0] f3, input logic [63:0] a,
                                input logic [63:0] wd);
        int n, base;
        n = 1 << f3[1:0];
        exp_err = (w ? (f3 >= 3'd4) : (f3 == 3'd7)) || (a > 64'(MEMB - 8));
`ifdef LSU_MISALIGN_TRAP_EN
        if (!exp_err && ((a % 64'(n)) != 64'd0)) exp_err = 1'b1;
`endif
        cur_w     = w;
        exp_maddr = a;
        exp_rdata = 64'd0;
        exp_wmem  = 64'd0;
        base      = int'(a[5:0]);
        if (exp_err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!w) begin
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
            for (int i = 0; i < n; i++) exp_rdata = exp_rdata | (64'(ref_mem[base + i]) << (8 * i));
            if (!f3[2] && (n < 8) && exp_rdata[8*n - 1])
                exp_rdata = exp_rdata | ~((64'd1 << (8 * n)) - 64'd1);
        end else begin
            exp_rd  = (n == 8) ? 0 : 1;
            exp_wr  = 1;
            exp_lat = (n == 8) ? 2 : 3;
            for (int i = 0; i < 8; i++)
                exp_wmem[8*i +: 8] = (i < n) ? wd[8*i +: 8] : ref_mem[base + i];
        end
    endtask

    task automatic model_commit();
        int base;
        base = int'(exp_maddr[5:0]);
        if (cur_w && !exp_err)
            for (int i = 0; i < 8; i++) ref_mem[base + i] = exp_wmem[8*i +: 8];
    endtask

    // Full transaction; hold = cycles resp_ready stays low, pend = present a
    // doubleword load of address 0 while waiting.
    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input int hold, input logic pend,
                           output logic [63:0] rd, output logic er);
        int lat, rd0, wr0;
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        model_expect(w, f3, a, wd);
        rd0 = rd_cnt; wr0 = wr_cnt;
        active = 1'b1;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        lat = 0;
        do begin
            tick();
            lat++;
            req_valid = 1'b0;
        end while (!resp_valid && lat < 10);
        check("latency", 64'(lat), 64'(exp_lat));
        check("memread_cycles", 64'(rd_cnt - rd0), 64'(exp_rd));
        check("memwrite_cycles", 64'(wr_cnt - wr0), 64'(exp_wr));
        rd = resp_rdata;
        er = resp_err;
        if (pend) begin
            req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd3;
            req_addr = 64'd0; req_wdata = 64'd0;
        end
        rd0 = rd_cnt;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", {63'd0, resp_valid}, 64'd1);
            check("hold_rdata", resp_rdata, rd);
        end
        check("no_accept_during_hold", 64'(rd_cnt - rd0), 64'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_dropped", {63'd0, resp_valid}, 64'd0);
        active = 1'b0;
        model_commit();
    endtask

    initial begin
        tests = 0; fails = 0; rd_cnt = 0; wr_cnt = 0; active = 1'b0;
        reset = 1'b1; mem_load = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b0;
        cur_w = 1'b0; exp_err = 1'b0; exp_rdata = 64'd0; exp_maddr = 64'd0; exp_wmem = 64'd0;
        exp_lat = 0; exp_rd = 0; exp_wr = 0;
        for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'(i + 9);

        #1;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_outputs", {60'd0, resp_valid, resp_err, MemRead, MemWrite}, 64'd0);
        check("rst_mem_addr", Mem_Addr, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        mem_load = 1'b0;
        tick();

        // Doubleword load from initialised memory.
        run_txn(1'b0, 3'd3, 64'd0, 64'd0, 0, 1'b0, got, gerr);
        check("ld0_literal", got, 64'h100F0E0D0C0B0A09);
        check("ld0_err", {63'd0, gerr}, 64'd0);

        // Halfword store (RMW) then signed / unsigned halfword loads.
        run_txn(1'b1, 3'd1, 64'd8, 64'h8001, 0, 1'b0, got, gerr);
        check("sh_rdata_zero", got, 64'd0);
        run_txn(1'b0, 3'd1, 64'd8, 64'd0, 0, 1'b0, got, gerr);
        check("lh8_literal", got, 64'hFFFFFFFFFFFF8001);
        run_txn(1'b0, 3'd5, 64'd8, 64'd0, 0, 1'b0, got, gerr);
        check("lhu8_literal", got, 64'h0000000000008001);

        // Byte store, neighbours untouched.
        run_txn(1'b1, 3'd0, 64'd16, 64'hAA, 0, 1'b0, got, gerr);
        run_txn(1'b0, 3'd3, 64'd16, 64'd0, 0, 1'b0, got, gerr);
        check("ld16_literal", got, 64'h201F1E1D1C1B1AAA);

        // Error cases: no memory cycles, 1-cycle latency, rdata 0.
        run_txn(1'b0, 3'd3, 64'd60, 64'd0, 0, 1'b0, got, gerr);
        check("ld60_err", {63'd0, gerr}, 64'd1);
        check("ld60_rdata", got, 64'd0);
        run_txn(1'b1, 3'd4, 64'd0, 64'h55, 0, 1'b0, got, gerr);
        check("st_f3_100_err", {63'd0, gerr}, 64'd1);
        run_txn(1'b0, 3'd7, 64'd0, 64'd0, 0, 1'b0, got, gerr);
        check("ld_f3_111_err", {63'd0, gerr}, 64'd1);
        run_txn(1'b0, 3'd3, 64'd56, 64'd0, 0, 1'b0, got, gerr);
        check("ld56_ok", {63'd0, gerr}, 64'd0);
        run_txn(1'b0, 3'd3, 64'd57, 64'd0, 0, 1'b0, got, gerr);
        check("ld57_err", {63'd0, gerr}, 64'd1);
        run_txn(1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 0, 1'b0, got, gerr);
        check("ld_wrap_err", {63'd0, gerr}, 64'd1);

        // Doubleword store and narrower extensions of it.
        run_txn(1'b1, 3'd3, 64'd32, 64'h8877665544332211, 0, 1'b0, got, gerr);
        run_txn(1'b0, 3'd0, 64'd39, 64'd0, 0, 1'b0, got, gerr);
        check("lb39_literal", got, 64'hFFFFFFFFFFFFFF88);
        run_txn(1'b0, 3'd4, 64'd39, 64'd0, 0, 1'b0, got, gerr);
        check("lbu39_literal", got, 64'h88);
        run_txn(1'b0, 3'd2, 64'd36, 64'd0, 0, 1'b0, got, gerr);
        check("lw36_literal", got, 64'hFFFFFFFF88776655);
        run_txn(1'b0, 3'd6, 64'd36, 64'd0, 0, 1'b0, got, gerr);
        check("lwu36_literal", got, 64'h88776655);
        run_txn(1'b0, 3'd2, 64'd32, 64'd0, 0, 1'b0, got, gerr);
        check("lw32_literal", got, 64'h44332211);

        // Misaligned access (legal unless the trap option is built in).
        run_txn(1'b0, 3'd3, 64'd3, 64'd0, 0, 1'b0, got, gerr);
        run_txn(1'b1, 3'd2, 64'd42, 64'hCAFEF00D, 0, 1'b0, got, gerr);
        run_txn(1'b0, 3'd3, 64'd40, 64'd0, 0, 1'b0, got, gerr);

        // Back-pressure with a pending request, then the pending ld 0.
        run_txn(1'b0, 3'd3, 64'd48, 64'd0, 5, 1'b1, got, gerr);
        check("ld48_literal", got, 64'h403F3E3D3C3B3A39);
        check("idle_after_hold", {63'd0, req_ready}, 64'd1);
        run_txn(1'b0, 3'd3, 64'd0, 64'd0, 0, 1'b0, got, gerr);
        check("pending_ld0", got, 64'h100F0E0D0C0B0A09);

        // Reset during the WR cycle of sw 24.
        model_expect(1'b1, 3'd2, 64'd24, 64'hDEADBEEF);
        active = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 64'd24; req_wdata = 64'hDEADBEEF;
        tick();
        req_valid = 1'b0;
        check("sw_rd_phase", {63'd0, MemRead}, 64'd1);
        tick();
        check("sw_wr_phase", {63'd0, MemWrite}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_memwrite_drop", {62'd0, MemWrite, MemRead}, 64'd0);
        check("rst_no_resp", {63'd0, resp_valid}, 64'd0);
        check("rst_req_ready_mid", {63'd0, req_ready}, 64'd1);
        active = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_resp_after_rst", {63'd0, resp_valid}, 64'd0);
        end
        run_txn(1'b0, 3'd3, 64'd24, 64'd0, 0, 1'b0, got, gerr);
        check("ld24_literal", got, 64'h2827262524232221);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
